// File: rtl/regfile_scoreboard_pkg.sv
// Shared CPU register-file constants and the architectural register address type,
// also used by decode and the hazard unit.
package regfile_scoreboard_pkg;

  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  typedef logic [AW_DEF-1:0] regaddr_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Read, writeback, issue and flush bundle between the pipeline and the register file.
// slave = register file side, master = pipeline side.
interface regfile_scoreboard_if #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]   rd_addr_i;
  logic [NRD*XLEN-1:0] rd_data_o;
  logic [NRD-1:0]      rd_busy_o;
  logic                wr_en_i;
  logic [AW-1:0]       wr_addr_i;
  logic [XLEN-1:0]     wr_data_i;
  logic                issue_en_i;
  logic [AW-1:0]       issue_addr_i;
  logic                flush_i;
  logic [AW:0]         busy_cnt_o;

  modport slave (
    input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, issue_en_i, issue_addr_i, flush_i,
    output rd_data_o, rd_busy_o, busy_cnt_o
  );

  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, issue_en_i, issue_addr_i, flush_i,
    input  rd_data_o, rd_busy_o, busy_cnt_o
  );
endinterface

// File: rtl/regfile_scoreboard_rdport.sv
// One combinational read port: register mux with same-cycle writeback bypass of data and busy.
// Zero latency; no backpressure.
module regfile_rdport #(
  parameter int XLEN     = 64,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [NREG-1:0][XLEN-1:0] mem_i,
  input  logic [NREG-1:0]           busy_i,
  input  logic [AW-1:0]             addr_i,
  input  logic                      byp_en_i,
  input  logic [AW-1:0]             byp_addr_i,
  input  logic [XLEN-1:0]           byp_data_i,
  output logic [XLEN-1:0]           data_o,
  output logic                      busy_o
);
  logic is_zero;
  logic hit;

  assign is_zero = (ZERO_REG != 0) && (addr_i == '0);
  assign hit     = byp_en_i && (byp_addr_i == addr_i);

  // A writeback in flight resolves the hazard this cycle, so it masks busy too.
  assign data_o = is_zero ? '0 : (hit ? byp_data_i : mem_i[addr_i]);
  assign busy_o = busy_i[addr_i] && !hit;
endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised integer register file with per-register busy scoreboard, busy counter and flush.
// Reads zero latency with write bypass; writes and scoreboard update on the rising edge; no backpressure.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  regfile_scoreboard_if.slave  bus
);
  localparam int AW = $clog2(NREG);
  localparam logic [AW:0] CNT_ONE = 1;

  logic [NREG-1:0][XLEN-1:0] mem_q;
  logic [NREG-1:0]           busy_q, busy_d;
  logic [AW:0]               cnt_q, cnt_d;
  logic                      set_new, clr_old;
  logic                      wr_ok;
  logic                      byp_en;

  assign wr_ok  = bus.wr_en_i && !((ZERO_REG != 0) && (bus.wr_addr_i == '0));
  // Bypass is gated by reset so the outputs read zero while reset is held.
  assign byp_en = bus.wr_en_i && rst_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_q <= '0;
    end else if (wr_ok) begin
      mem_q[bus.wr_addr_i] <= bus.wr_data_i;
    end
  end

  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    set_new = bus.issue_en_i && !busy_q[bus.issue_addr_i]
              && !((ZERO_REG != 0) && (bus.issue_addr_i == '0));
    // Issue to the same register as the writeback keeps the bit set, so nothing is cleared.
    clr_old = bus.wr_en_i && busy_q[bus.wr_addr_i]
              && !(bus.issue_en_i && (bus.issue_addr_i == bus.wr_addr_i));
    if (bus.flush_i) begin
      busy_d = '0;
      cnt_d  = '0;
    end else begin
      if (bus.wr_en_i)    busy_d[bus.wr_addr_i]    = 1'b0;
      if (bus.issue_en_i) busy_d[bus.issue_addr_i] = 1'b1;
      if (ZERO_REG != 0)  busy_d[0]                = 1'b0;
      case ({set_new, clr_old})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.busy_cnt_o = cnt_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rdport
    regfile_rdport #(
      .XLEN     (XLEN),
      .NREG     (NREG),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_rdport (
      .mem_i      (mem_q),
      .busy_i     (busy_q),
      .addr_i     (bus.rd_addr_i[k*AW +: AW]),
      .byp_en_i   (byp_en),
      .byp_addr_i (bus.wr_addr_i),
      .byp_data_i (bus.wr_data_i),
      .data_o     (bus.rd_data_o[k*XLEN +: XLEN]),
      .busy_o     (bus.rd_busy_o[k])
    );
  end
endmodule
